rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered 32-bit bridge words (power of two, >=2).
REQ-002 SHALL have port clk_mem  input  1  memory clock; all logic synchronous to its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ioctl_download  input  1  high while the ROM data slot is being transferred.
REQ-005 SHALL have port rom_file_size  input  32  file size in bytes, stable while ioctl_download is high.
REQ-006 SHALL have port bridge_wr  input  1  one-cycle write strobe from the bridge.
REQ-007 SHALL have port bridge_addr  input  32  byte file offset of the write; bits [1:0] ignored.
REQ-008 SHALL have port bridge_wr_data  input  32  big-endian data word; [31:24] is the byte at offset+0.
REQ-009 SHALL have port sdram_wr  output  1  write request, held until acknowledged.
REQ-010 SHALL have port sdram_addr  output  25  header-stripped byte address of the halfword.
REQ-011 SHALL have port sdram_data  output  16  halfword; [7:0] = even byte, [15:8] = odd byte.
REQ-012 SHALL have port sdram_ack  input  1  one-cycle acknowledge of the current request.
REQ-013 SHALL have port downloading  output  1  active-download indication to the header parser.
REQ-014 SHALL have port addr  output  25  raw file byte offset of the last issued halfword (parser tap).
REQ-015 SHALL have port data  output  16  last issued halfword (parser tap), same format as sdram_data.
REQ-016 SHALL have port fifo_overflow  output  1  sticky dropped-write flag.

Function
REQ-017 SHALL derive header_skip = rom_file_size[9]; offset = 0x200 when set, else 0.
REQ-018 SHALL push {bridge_addr[24:2], bridge_wr_data} into the FIFO when bridge_wr and ioctl_download are high and the FIFO is not full, evaluated on the count at the start of the cycle; a same-cycle pop does not free space.
REQ-019 SHALL drop a write arriving while full and set fifo_overflow, which holds until the next download start.
REQ-020 SHALL run FSM IDLE -> WR_LO -> WR_HI -> IDLE; IDLE moves to WR_LO when the FIFO is non-empty.
REQ-021 SHALL in WR_LO emit halfword {data[23:16], data[31:24]} at byte offset {a,2'b00}; in WR_HI emit {data[7:0], data[15:8]} at {a,2'b10}.
REQ-022 SHALL for each emitted halfword assert sdram_wr with sdram_addr = offset-in-file minus header offset, hold sdram_wr/sdram_addr/sdram_data stable until sdram_ack, then deassert sdram_wr for at least one cycle.
REQ-023 SHALL skip (no sdram_wr, zero cycles waiting) any halfword whose file offset < header offset; the state still advances.
REQ-024 SHALL update addr/data to the halfword's raw file offset and value in the cycle sdram_wr is first asserted for it, and hold them until the next issued halfword.
REQ-025 SHALL pop the FIFO entry on leaving WR_HI (ack received or skipped).
REQ-026 SHALL raise downloading one cycle after a rising edge of ioctl_download; at that edge, clear the FIFO and fifo_overflow and zero addr.
REQ-027 SHALL, after ioctl_download is low, the FIFO is empty and the FSM is in IDLE, enter FLUSH: drive addr = 0 for 2 cycles, then clear downloading, so that the parser closes its last header window before seeing the falling edge.
REQ-028 SHALL ignore sdram_ack outside WR_LO/WR_HI, and ignore bridge_wr while ioctl_download is low.
REQ-029 SHALL treat ioctl_download rising during FLUSH as a new download: discard the flush and restart per REQ-026.

Reset
REQ-030 SHALL on reset clear the FIFO, FSM to IDLE, sdram_wr=0, sdram_addr=0, sdram_data=0, addr=0, data=0, downloading=0, fifo_overflow=0.
REQ-031 SHALL, when reset deasserts with ioctl_download already high, stay idle until a new rising edge of ioctl_download.

Verification
REQ-032 No header (size 0x8000): write 0x12345678 at 0x7FFC, ack after 3 cycles -> sdram writes (0x7FFC, 0x3412), (0x7FFE, 0x7856); addr/data track both.
REQ-033 Header (size 0x8200): words at 0x1FC and 0x200 -> 0x1FC produces no sdram_wr; 0x200 produces sdram_addr 0x000 and 0x002; addr reads 0x200 and 0x202.
REQ-034 FIFO_DEPTH=4, ack held low, 6 back-to-back bridge_wr -> 4 accepted, fifo_overflow=1; after acks, exactly 8 halfwords written in address order.
REQ-035 ioctl_download falls with 2 words queued -> downloading stays high until 4 acks, then addr=0 for 2 cycles, then downloading=0.
REQ-036 Reset asserted mid-WR_HI with sdram_wr high -> next cycle sdram_wr=0, downloading=0, FIFO empty; no restart while ioctl_download stays high.
REQ-037 New ioctl_download rise during FLUSH -> fifo_overflow cleared, downloading stays high, addr=0, FSM IDLE.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: buffers big-endian bridge words in a small FIFO and replays them to
// SDRAM as byte-swapped halfwords, stripping an optional 512-byte file header.
module rom_loader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [31:0] rom_file_size,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  output logic        sdram_wr,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_data,
  input  logic        sdram_ack,
  output logic        downloading,
  output logic [24:0] addr,
  output logic [15:0] data,
  output logic        fifo_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, FLUSH} state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [22:0]   r_fifoAddr [FIFO_DEPTH];
  logic [31:0]   r_fifoData [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;

  logic          r_dlPrev;
  logic          r_downloading;
  logic          r_overflow;
  logic          r_issued;
  logic          r_flushCnt;
  logic          r_sdramWr;
  logic [24:0]   r_sdramAddr;
  logic [15:0]   r_sdramData;
  logic [24:0]   r_addr;
  logic [15:0]   r_data;

  logic          w_dlRise;
  logic          w_empty;
  logic          w_full;
  logic          w_wrValid;
  logic          w_push;
  logic          w_drop;
  logic [24:0]   w_hdrOff;
  logic [31:0]   w_headData;
  logic [24:0]   w_hwOff;
  logic [15:0]   w_hwData;
  logic          w_skip;
  logic          w_issue;
  logic          w_advance;
  logic          w_pop;
  logic          w_flushStart;
  logic          w_flushDone;
  logic          w_unused;

  // r_dlPrev comes out of reset high so an already-active download is not seen as a new one
  assign w_dlRise   = ioctl_download & ~r_dlPrev;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH);
  assign w_wrValid  = bridge_wr & ioctl_download & r_downloading & ~w_dlRise;
  assign w_push     = w_wrValid & ~w_full;
  assign w_drop     = w_wrValid & w_full;
  assign w_hdrOff   = rom_file_size[9] ? 25'h200 : 25'h0;
  assign w_headData = r_fifoData[r_rdPtr];
  assign w_hwOff    = {r_fifoAddr[r_rdPtr], (r_state == WR_HI), 1'b0};
  assign w_hwData   = (r_state == WR_HI) ? {w_headData[7:0], w_headData[15:8]}
                                         : {w_headData[23:16], w_headData[31:24]};
  assign w_skip     = (w_hwOff < w_hdrOff);
  assign w_unused   = ^{rom_file_size[31:10], rom_file_size[8:0], bridge_addr[31:25], bridge_addr[1:0]};

  assign sdram_wr      = r_sdramWr;
  assign sdram_addr    = r_sdramAddr;
  assign sdram_data    = r_sdramData;
  assign downloading   = r_downloading;
  assign addr          = r_addr;
  assign data          = r_data;
  assign fifo_overflow = r_overflow;

  always_ff @(posedge clk_mem) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_issue      = 1'b0;
    w_advance    = 1'b0;
    w_pop        = 1'b0;
    w_flushStart = 1'b0;
    w_flushDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_nextState = WR_LO;
        end else if (r_downloading && !ioctl_download) begin
          w_nextState  = FLUSH;
          w_flushStart = 1'b1;
        end
      end
      WR_LO, WR_HI: begin
        if (!r_issued) begin
          if (w_skip) w_advance = 1'b1;
          else        w_issue   = 1'b1;
        end else if (sdram_ack) begin
          w_advance = 1'b1;
        end
        if (w_advance) begin
          w_nextState = (r_state == WR_LO) ? WR_HI : IDLE;
          w_pop       = (r_state == WR_HI);
        end
      end
      FLUSH: begin
        if (r_flushCnt) begin
          w_nextState = IDLE;
          w_flushDone = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
    // A new download start overrides whatever the engine was doing
    if (w_dlRise) begin
      w_nextState  = IDLE;
      w_issue      = 1'b0;
      w_advance    = 1'b0;
      w_pop        = 1'b0;
      w_flushStart = 1'b0;
      w_flushDone  = 1'b0;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr] <= bridge_addr[24:2];
      r_fifoData[r_wrPtr] <= bridge_wr_data;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_dlPrev      <= 1'b1;
      r_downloading <= 1'b0;
      r_overflow    <= 1'b0;
      r_issued      <= 1'b0;
      r_flushCnt    <= 1'b0;
      r_sdramWr     <= 1'b0;
      r_sdramAddr   <= '0;
      r_sdramData   <= '0;
      r_addr        <= '0;
      r_data        <= '0;
    end else begin
      r_dlPrev <= ioctl_download;
      if (w_dlRise) begin
        r_wrPtr       <= '0;
        r_rdPtr       <= '0;
        r_count       <= '0;
        r_overflow    <= 1'b0;
        r_addr        <= '0;
        r_downloading <= 1'b1;
        r_sdramWr     <= 1'b0;
        r_issued      <= 1'b0;
        r_flushCnt    <= 1'b0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        if (w_drop) r_overflow <= 1'b1;
        if (w_issue) begin
          r_sdramWr   <= 1'b1;
          r_sdramAddr <= w_hwOff - w_hdrOff;
          r_sdramData <= w_hwData;
          r_addr      <= w_hwOff;
          r_data      <= w_hwData;
          r_issued    <= 1'b1;
        end else if (w_advance) begin
          r_sdramWr <= 1'b0;
          r_issued  <= 1'b0;
        end
        // Parser sees addr = 0 for the two flush cycles before downloading drops
        if (w_flushStart) begin
          r_addr     <= '0;
          r_flushCnt <= 1'b0;
        end else if (r_state == FLUSH) begin
          r_flushCnt <= 1'b1;
        end
        if (w_flushDone) r_downloading <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven single-word downloads plus hand-written sequences for
// FIFO overflow, flush timing, restart during flush and reset mid-write.
module tb_rom_loader;

  logic        clk_mem = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [31:0] rom_file_size = '0;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_addr = '0;
  logic [31:0] bridge_wr_data = '0;
  logic        sdram_wr;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        sdram_ack = 1'b0;
  logic        downloading;
  logic [24:0] addr;
  logic [15:0] data;
  logic        fifo_overflow;

  int checks = 0;
  int failures = 0;
  int wrStarts = 0;
  logic prevWr = 1'b0;

  rom_loader #(.FIFO_DEPTH(4)) dut (
    .clk_mem(clk_mem), .reset(reset), .ioctl_download(ioctl_download),
    .rom_file_size(rom_file_size), .bridge_wr(bridge_wr), .bridge_addr(bridge_addr),
    .bridge_wr_data(bridge_wr_data), .sdram_wr(sdram_wr), .sdram_addr(sdram_addr),
    .sdram_data(sdram_data), .sdram_ack(sdram_ack), .downloading(downloading),
    .addr(addr), .data(data), .fifo_overflow(fifo_overflow)
  );

  always #5 clk_mem = ~clk_mem;

  // Counts each new SDRAM request so skipped or spurious writes show up
  always @(negedge clk_mem) begin
    if (sdram_wr && !prevWr) wrStarts++;
    prevWr = sdram_wr;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic [31:0] size;
    logic [31:0] bAddr;
    logic [31:0] bData;
    logic [1:0]  n;
    logic [1:0]  ackDly;
    logic [24:0] s0;
    logic [15:0] d0;
    logic [24:0] r0;
    logic [24:0] s1;
    logic [15:0] d1;
    logic [24:0] r1;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    bridge_wr      = 1'b1;
    bridge_addr    = a;
    bridge_wr_data = d;
    step();
    bridge_wr = 1'b0;
  endtask

  task automatic startDownload(input logic [31:0] size);
    rom_file_size  = size;
    ioctl_download = 1'b1;
    step();
    checkOutput("dl_rise", {31'd0, downloading}, 32'd1);
  endtask

  task automatic serviceOne(input string tag, input logic [24:0] eS, input logic [15:0] eD,
                            input logic [24:0] eR, input int dly);
    int cyc = 0;
    while (!sdram_wr && cyc < 50) begin
      step();
      cyc++;
    end
    checkOutput({tag, "_wait"}, {31'd0, sdram_wr}, 32'd1);
    if (sdram_wr) begin
      checkOutput({tag, "_saddr"}, {7'd0, sdram_addr}, {7'd0, eS});
      checkOutput({tag, "_sdata"}, {16'd0, sdram_data}, {16'd0, eD});
      checkOutput({tag, "_addr"}, {7'd0, addr}, {7'd0, eR});
      checkOutput({tag, "_data"}, {16'd0, data}, {16'd0, eD});
      for (int i = 0; i < dly; i++) begin
        step();
        checkOutput({tag, "_hold"}, {6'd0, sdram_wr, sdram_addr}, {6'd0, 1'b1, eS});
      end
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      checkOutput({tag, "_drop"}, {31'd0, sdram_wr}, 32'd0);
    end
  endtask

  task automatic waitDownloadEnd(input string tag);
    int cyc = 0;
    while (downloading && cyc < 40) begin
      step();
      cyc++;
    end
    checkOutput(tag, {31'd0, downloading}, 32'd0);
  endtask

  function automatic vec_t mkVec(input logic [31:0] size, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] n, input logic [1:0] dly,
                                 input logic [24:0] s0, input logic [15:0] d0, input logic [24:0] r0,
                                 input logic [24:0] s1, input logic [15:0] d1, input logic [24:0] r1);
    vec_t v;
    v.size = size; v.bAddr = a; v.bData = d; v.n = n; v.ackDly = dly;
    v.s0 = s0; v.d0 = d0; v.r0 = r0; v.s1 = s1; v.d1 = d1; v.r1 = r1;
    return v;
  endfunction

  initial begin
    int base;
    logic [7:0] b;
    logic [24:0] o;

    vecs[0] = mkVec(32'h8000, 32'h7FFC, 32'h12345678, 2'd2, 2'd3,
                    25'h7FFC, 16'h3412, 25'h7FFC, 25'h7FFE, 16'h7856, 25'h7FFE);
    vecs[1] = mkVec(32'h8200, 32'h01FC, 32'hAABBCCDD, 2'd0, 2'd0,
                    25'h0, 16'h0, 25'h0, 25'h0, 16'h0, 25'h0);
    vecs[2] = mkVec(32'h8200, 32'h0200, 32'hCAFEBABE, 2'd2, 2'd1,
                    25'h000, 16'hFECA, 25'h200, 25'h002, 16'hBEBA, 25'h202);
    vecs[3] = mkVec(32'h8200, 32'h1234, 32'h01020304, 2'd2, 2'd0,
                    25'h1034, 16'h0201, 25'h1234, 25'h1036, 16'h0403, 25'h1236);
    vecs[4] = mkVec(32'h0400, 32'h0000, 32'hDEADBEEF, 2'd2, 2'd2,
                    25'h0, 16'hADDE, 25'h0, 25'h2, 16'hEFBE, 25'h2);
    vecs[5] = mkVec(32'h0200, 32'h03FF, 32'h11223344, 2'd2, 2'd1,
                    25'h1FC, 16'h2211, 25'h3FC, 25'h1FE, 16'h4433, 25'h3FE);

    repeat (3) step();
    checkOutput("rst_sdram_wr", {31'd0, sdram_wr}, 32'd0);
    checkOutput("rst_sdram_addr", {7'd0, sdram_addr}, 32'd0);
    checkOutput("rst_sdram_data", {16'd0, sdram_data}, 32'd0);
    checkOutput("rst_addr", {7'd0, addr}, 32'd0);
    checkOutput("rst_data", {16'd0, data}, 32'd0);
    checkOutput("rst_downloading", {31'd0, downloading}, 32'd0);
    checkOutput("rst_overflow", {31'd0, fifo_overflow}, 32'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      startDownload(vecs[v].size);
      base = wrStarts;
      applyStimulus(vecs[v].bAddr, vecs[v].bData);
      ioctl_download = 1'b0;
      if (vecs[v].n >= 2'd1) serviceOne($sformatf("vec%0d_lo", v), vecs[v].s0, vecs[v].d0, vecs[v].r0, int'(vecs[v].ackDly));
      if (vecs[v].n >= 2'd2) serviceOne($sformatf("vec%0d_hi", v), vecs[v].s1, vecs[v].d1, vecs[v].r1, int'(vecs[v].ackDly));
      waitDownloadEnd($sformatf("vec%0d_end", v));
      checkOutput($sformatf("vec%0d_count", v), wrStarts - base, {30'd0, vecs[v].n});
    end

    // Download ends with two words still queued: flush must wait for all four acks
    startDownload(32'h8000);
    applyStimulus(32'h100, 32'hA1B2C3D4);
    applyStimulus(32'h104, 32'h55667788);
    ioctl_download = 1'b0;
    checkOutput("fl_dl_0", {31'd0, downloading}, 32'd1);
    serviceOne("fl_h0", 25'h100, 16'hB2A1, 25'h100, 1);
    checkOutput("fl_dl_1", {31'd0, downloading}, 32'd1);
    serviceOne("fl_h1", 25'h102, 16'hD4C3, 25'h102, 0);
    checkOutput("fl_dl_2", {31'd0, downloading}, 32'd1);
    serviceOne("fl_h2", 25'h104, 16'h6655, 25'h104, 2);
    checkOutput("fl_dl_3", {31'd0, downloading}, 32'd1);
    serviceOne("fl_h3", 25'h106, 16'h8877, 25'h106, 0);
    checkOutput("fl_last_addr", {7'd0, addr}, 32'h106);
    checkOutput("fl_last_dl", {31'd0, downloading}, 32'd1);
    step();
    checkOutput("fl_c1_addr", {7'd0, addr}, 32'd0);
    checkOutput("fl_c1_dl", {31'd0, downloading}, 32'd1);
    step();
    checkOutput("fl_c2_addr", {7'd0, addr}, 32'd0);
    checkOutput("fl_c2_dl", {31'd0, downloading}, 32'd1);
    step();
    checkOutput("fl_end_dl", {31'd0, downloading}, 32'd0);

    // Six back-to-back writes with no ack: four fit, the rest set the overflow flag
    startDownload(32'h8000);
    for (int i = 0; i < 6; i++) begin
      b = 8'(4 * i);
      applyStimulus(32'(4 * i), {b, b + 8'd1, b + 8'd2, b + 8'd3});
      if (i == 3) checkOutput("ov_at_full", {31'd0, fifo_overflow}, 32'd0);
    end
    checkOutput("ov_set", {31'd0, fifo_overflow}, 32'd1);
    ioctl_download = 1'b0;
    for (int k = 0; k < 8; k++) begin
      o = 25'(2 * k);
      serviceOne($sformatf("ov_h%0d", k), o, {o[7:0] + 8'd1, o[7:0]}, o, k % 3);
    end
    step();
    checkOutput("rs_flush_addr", {7'd0, addr}, 32'd0);
    checkOutput("rs_flush_dl", {31'd0, downloading}, 32'd1);
    checkOutput("rs_flush_ov", {31'd0, fifo_overflow}, 32'd1);
    // Restart while flushing
    ioctl_download = 1'b1;
    step();
    checkOutput("rs_ov_clr", {31'd0, fifo_overflow}, 32'd0);
    checkOutput("rs_dl", {31'd0, downloading}, 32'd1);
    checkOutput("rs_addr", {7'd0, addr}, 32'd0);
    checkOutput("rs_wr", {31'd0, sdram_wr}, 32'd0);
    step();
    step();
    checkOutput("rs_dl_hold", {31'd0, downloading}, 32'd1);
    ioctl_download = 1'b0;
    waitDownloadEnd("rs_end");

    // Reset while the high halfword request is pending
    startDownload(32'h8000);
    applyStimulus(32'h40, 32'h01020304);
    serviceOne("rr_lo", 25'h40, 16'h0201, 25'h40, 0);
    step();
    checkOutput("rr_hi_pending", {31'd0, sdram_wr}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rr_wr", {31'd0, sdram_wr}, 32'd0);
    checkOutput("rr_dl", {31'd0, downloading}, 32'd0);
    checkOutput("rr_saddr", {7'd0, sdram_addr}, 32'd0);
    checkOutput("rr_data", {16'd0, data}, 32'd0);
    base = wrStarts;
    applyStimulus(32'h80, 32'h99887766);
    repeat (10) step();
    checkOutput("rr_no_restart", wrStarts - base, 32'd0);
    checkOutput("rr_dl_idle", {31'd0, downloading}, 32'd0);
    ioctl_download = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
